// File: rtl/data_unpack_pkg.sv
// data_unpack_pkg
//   Shared definitions for the 32-to-7 unpacker: default widths, derived
//   accumulator sizes and the FSM state type.
//   Optional feature macro: DATA_UNPACK_EOP_FLUSH_EN (see data_unpack_32to7).
package data_unpack_pkg;

    localparam int unsigned IN_W_DEF  = 32;
    localparam int unsigned OUT_W_DEF = 7;

    // Largest residual (OUT_W-1) plus one full input word.
    localparam int unsigned BUF_W = IN_W_DEF + OUT_W_DEF - 1;
    localparam int unsigned CNT_W = $clog2(BUF_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/data_unpack_acc.sv
// data_unpack_acc
//   Bit accumulator for the unpacker. Holds the bit buffer and its fill
//   count. One cycle applies, in order: optional clear, optional append of
//   an input word above the residual bits, optional shift by OUT_W, and an
//   optional drop that empties the buffer after the shift.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     clr_i         discard residual bits before appending
//     load_i        append data_i above the current residual
//     data_i        word to append, bit 0 lands at position cnt
//     shift_i       consume one OUT_W symbol from the bottom
//     drop_i        empty the buffer after this cycle's operations
//     sym_o         low OUT_W bits of the staged (post-append) buffer
//     stage_cnt_o   fill count of the staged (post-append) buffer
module data_unpack_acc
    import data_unpack_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clr_i,
    input  logic                                 load_i,
    input  logic [IN_W-1:0]                      data_i,
    input  logic                                 shift_i,
    input  logic                                 drop_i,
    output logic [OUT_W-1:0]                     sym_o,
    output logic [$clog2(IN_W+OUT_W)-1:0]        stage_cnt_o
);

    localparam int unsigned BW = IN_W + OUT_W - 1;
    localparam int unsigned CW = $clog2(BW + 1);

    localparam logic [CW-1:0] IN_W_C  = CW'(IN_W);
    localparam logic [CW-1:0] OUT_W_C = CW'(OUT_W);

    logic [BW-1:0] buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] base_buf, stg_buf;
    logic [CW-1:0] base_cnt, stg_cnt;

    always_comb begin
        base_buf = clr_i ? '0 : buf_q;
        base_cnt = clr_i ? '0 : cnt_q;

        stg_buf = base_buf;
        stg_cnt = base_cnt;
        if (load_i) begin
            stg_buf = base_buf | (BW'(data_i) << base_cnt);
            stg_cnt = base_cnt + IN_W_C;
        end

        buf_d = stg_buf;
        cnt_d = stg_cnt;
        if (shift_i) begin
            buf_d = stg_buf >> OUT_W;
            cnt_d = (stg_cnt >= OUT_W_C) ? (stg_cnt - OUT_W_C) : '0;
        end

        if (drop_i) begin
            buf_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign sym_o       = stg_buf[OUT_W-1:0];
    assign stage_cnt_o = stg_cnt;

endmodule

// File: rtl/data_unpack_32to7.sv
// data_unpack_32to7
//   Unpacks a stream of IN_W-bit words into OUT_W-bit symbols, LSB first,
//   carrying leftover bits across word boundaries and preserving packet
//   framing. No output back-pressure: a word is taken only in IDLE and its
//   symbols are then emitted back to back.
//   Optional feature: define DATA_UNPACK_EOP_FLUSH_EN to emit the 1..OUT_W-1
//   residual bits of an eop word as a final zero-padded symbol; otherwise
//   those bits are dropped.
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     valid_in    data_in/sop_in/eop_in are valid
//     data_in     input word, bit 0 consumed first
//     sop_in      first word of a packet (discards residual bits)
//     eop_in      last word of a packet
//     ready_out   a word can be accepted this cycle
//     valid_out   data_out holds a symbol
//     data_out    output symbol
//     sop_out     first symbol of a packet
//     eop_out     last symbol of a packet
module data_unpack_32to7
    import data_unpack_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [IN_W-1:0]   data_in,
    input  logic              sop_in,
    input  logic              eop_in,
    output logic              ready_out,
    output logic              valid_out,
    output logic [OUT_W-1:0]  data_out,
    output logic              sop_out,
    output logic              eop_out
);

    localparam int unsigned BW = IN_W + OUT_W - 1;
    localparam int unsigned CW = $clog2(BW + 1);

    localparam logic [CW-1:0] OUT_W_C = CW'(OUT_W);

    state_e            state_q;
    logic              ready_q;
    logic              valid_q;
    logic [OUT_W-1:0]  data_q;
    logic              sop_q;
    logic              eop_q;
    logic              last_q;      // symbol on the outputs is the last of its word
    logic              eop_pend_q;

    logic              accept;
    logic              emitting;
    logic              eop_cur;
    logic              last_sym;
    logic              drop;
    logic [OUT_W-1:0]  sym;
    logic [CW-1:0]     stage_cnt;
    logic [CW-1:0]     rem;

    assign accept   = valid_in && ready_q;
    // A symbol is produced on the accept edge itself so that the first
    // symbol is already registered in the cycle following acceptance.
    assign emitting = accept || ((state_q == EMIT) && !last_q);
    assign eop_cur  = accept ? eop_in : eop_pend_q;
    assign rem      = (stage_cnt >= OUT_W_C) ? (stage_cnt - OUT_W_C) : '0;

`ifdef DATA_UNPACK_EOP_FLUSH_EN
    logic flush_next;
    assign flush_next = eop_cur && (rem != '0);
    assign last_sym   = (rem < OUT_W_C) && !flush_next;
`else
    assign last_sym   = rem < OUT_W_C;
`endif

    // At the end of a packet whatever is left is discarded so the next
    // packet starts from an empty buffer.
    assign drop = emitting && last_sym && eop_cur;

    data_unpack_acc #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (accept && sop_in),
        .load_i      (accept),
        .data_i      (data_in),
        .shift_i     (emitting),
        .drop_i      (drop),
        .sym_o       (sym),
        .stage_cnt_o (stage_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            data_q     <= '0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            last_q     <= 1'b0;
            eop_pend_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= EMIT;
                        ready_q    <= 1'b0;
                        valid_q    <= 1'b1;
                        data_q     <= sym;
                        sop_q      <= sop_in;
                        eop_q      <= eop_in && last_sym;
                        last_q     <= last_sym;
                        eop_pend_q <= eop_in;
                    end else begin
                        valid_q <= 1'b0;
                        data_q  <= '0;
                        sop_q   <= 1'b0;
                        eop_q   <= 1'b0;
                    end
                end
                EMIT: begin
                    if (last_q) begin
                        state_q    <= IDLE;
                        ready_q    <= 1'b1;
                        valid_q    <= 1'b0;
                        data_q     <= '0;
                        sop_q      <= 1'b0;
                        eop_q      <= 1'b0;
                        last_q     <= 1'b0;
                        eop_pend_q <= 1'b0;
                    end else begin
                        valid_q <= 1'b1;
                        data_q  <= sym;
                        sop_q   <= 1'b0;
                        eop_q   <= eop_cur && last_sym;
                        last_q  <= last_sym;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_out = ready_q;
    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign sop_out   = sop_q;
    assign eop_out   = eop_q;

endmodule

// File: tb/tb_data_unpack_32to7.sv
`timescale 1ns/1ps
module tb_data_unpack_32to7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic        sop_in = 1'b0;
    logic        eop_in = 1'b0;
    logic        ready_out;
    logic        valid_out;
    logic [6:0]  data_out;
    logic        sop_out;
    logic        eop_out;

    data_unpack_32to7 #(
        .IN_W  (32),
        .OUT_W (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .sop_in    (sop_in),
        .eop_in    (eop_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sop_out   (sop_out),
        .eop_out   (eop_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] d;
        logic       s;
        logic       e;
    } sym_t;

    sym_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic        mon_en = 1'b0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expectation per presented symbol.
    always @(negedge clk) begin
        sym_t e;
        if (mon_en) begin
            if (valid_out === 1'b1 && ready_out === 1'b1) begin
                n_vec++;
                n_bad++;
                $display("FAIL excl: ready_out=%b valid_out=%b required not both 1", ready_out, valid_out);
            end
            if (valid_out === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sym: unexpected symbol data=%h sop=%b eop=%b", data_out, sop_out, eop_out);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out !== e.d || sop_out !== e.s || eop_out !== e.e) begin
                        n_bad++;
                        $display("FAIL sym: got data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                                 data_out, sop_out, eop_out, e.d, e.s, e.e);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    task automatic push(input logic [6:0] d, input logic s, input logic e);
        sym_t x;
        x.d = d;
        x.s = s;
        x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic push_ff(input int unsigned k, input logic s, input logic e);
        for (int unsigned i = 0; i < k; i++)
            push(7'h7F, s && (i == 0), e && (i == k - 1));
    endtask

    // Symbols of 0x12345678 sent as a single-word packet.
    task automatic push_w1234();
        push(7'h78, 1'b1, 1'b0);
        push(7'h2C, 1'b0, 1'b0);
        push(7'h51, 1'b0, 1'b0);
`ifdef DATA_UNPACK_EOP_FLUSH_EN
        push(7'h11, 1'b0, 1'b0);
        push(7'h01, 1'b0, 1'b1);
`else
        push(7'h11, 1'b0, 1'b1);
`endif
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [31:0] d, input logic s, input logic e, input bit keep);
        int unsigned budget = 0;
        data_in  = d;
        sop_in   = s;
        eop_in   = e;
        valid_in = 1'b1;
        while (ready_out !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: ready_out=%b required 1 within 100 cycles", ready_out);
        end
        @(posedge clk);
        acc_cyc = cyc;
        @(negedge clk);
        if (!keep) valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned budget = 0;
        while ((exp_q.size() != 0 || ready_out !== 1'b1) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k7[7];
        int unsigned prev_cyc;
        k7 = '{4, 5, 4, 5, 4, 5, 5};

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_ready", ready_out, 1);
        chk("rst_valid", valid_out, 0);
        chk("rst_sop", sop_out, 0);
        chk("rst_eop", eop_out, 0);
        chk("rst_data", data_out, 0);
        rst = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);

        // Single-word packet.
        push_w1234();
        send(32'h12345678, 1'b1, 1'b1, 1'b0);
        wait_idle();

        // Seven all-ones words with valid_in held high throughout.
        prev_cyc = 0;
        for (int unsigned i = 0; i < 7; i++) begin
            push_ff(k7[i], i == 0, i == 6);
            send(32'hFFFFFFFF, i == 0, i == 6, i != 6);
            if (i > 0) chk("word_period", acc_cyc - prev_cyc, 1 + k7[i-1]);
            prev_cyc = acc_cyc;
        end
        wait_idle();

        // All-ones word as a one-word packet: 4 residual bits at eop.
`ifdef DATA_UNPACK_EOP_FLUSH_EN
        push_ff(4, 1'b1, 1'b0);
        push(7'h0F, 1'b0, 1'b1);
`else
        push_ff(4, 1'b1, 1'b1);
`endif
        send(32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        wait_idle();

        // Reset in the middle of EMIT.
        @(posedge clk);
        #1 mon_en = 1'b0;
        @(negedge clk);
        send(32'h12345678, 1'b1, 1'b0, 1'b0);
        chk("mid_valid", valid_out, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("postrst_valid", valid_out, 0);
        chk("postrst_ready", ready_out, 1);
        chk("postrst_sop", sop_out, 0);
        chk("postrst_eop", eop_out, 0);
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);

        // Fresh sop word, no eop: symbols from data_in[27:0] only.
        push(7'h01, 1'b1, 1'b0);
        push(7'h02, 1'b0, 1'b0);
        push(7'h03, 1'b0, 1'b0);
        push(7'h04, 1'b0, 1'b0);
        send(32'hF080C101, 1'b1, 1'b0, 1'b0);

        // Six words leave 3 residual bits; the sop word then discards them.
        for (int unsigned i = 0; i < 6; i++) begin
            push_ff(k7[i], i == 0, 1'b0);
            send(32'hFFFFFFFF, i == 0, 1'b0, 1'b0);
        end
        push_w1234();
        send(32'h12345678, 1'b1, 1'b1, 1'b0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/data_unpack_32to7.md
# data_unpack_32to7

Width converter that unpacks a stream of 32-bit words into a stream of 7-bit symbols, LSB first, carrying leftover bits across word boundaries. It sits between a 32-bit packet source and a 7-bit symbol consumer and preserves packet framing (start/end of packet). Seven input words produce exactly 32 output symbols. There is no output back-pressure.

## Interface
- IN_W, 32: input word width.
- OUT_W, 7: output symbol width; must satisfy OUT_W <= IN_W.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- valid_in  in  1  data_in, sop_in and eop_in are valid.
- data_in  in  IN_W  input word; bit 0 is consumed first.
- sop_in  in  1  word is the first of a packet.
- eop_in  in  1  word is the last of a packet.
- ready_out  out  1  block can accept a word this cycle.
- valid_out  out  1  data_out holds a symbol this cycle.
- data_out  out  OUT_W  output symbol.
- sop_out  out  1  first symbol of a packet.
- eop_out  out  1  last symbol of a packet.

## Operation
- State registers: bit buffer `buf` (IN_W+OUT_W-1 = 38 bits) and bit count `cnt` (0..38).
- FSM has two states:
  - IDLE: ready_out=1, valid_out=0.
  - EMIT: ready_out=0, valid_out=1.
- Accept: valid_in && ready_out at a rising edge.
  - If sop_in=1, residual bits are discarded first.
  - The new word is appended above the residual bits: buf |= data_in << cnt, cnt += 32.
  - Flags sop_pend=sop_in and eop_pend=eop_in are latched.
  - State goes to EMIT.
- valid_in while ready_out=0 is ignored; the word is not consumed.
- EMIT, each cycle:
  - data_out = buf[6:0].
  - sop_out = sop_pend; sop_pend clears after the first symbol.
  - Then buf >>= 7 and cnt -= 7 (saturating at 0).
- EMIT ends, returning to IDLE, when the symbol being emitted leaves cnt < 7, unless a flush is pending.
- Symbols per non-eop word are floor((cnt+32)/7): 4 or 5.
- EOP: see Configuration. After the final symbol of a packet, buf and cnt are 0.
- sop_in and eop_in on the same word form a single-word packet: sop_out is on the first symbol and eop_out on the last.
- A reset mid-packet discards buf, cnt and pending flags, and drops any partially emitted packet.

## Timing
- Reset values, from the first edge with rst=1: state IDLE, ready_out=1, valid_out=0, sop_out=0, eop_out=0, data_out=0, cnt=0.
- Latency:
  - A word accepted at edge N makes ready_out=0 from N.
  - The first symbol is valid in the cycle after N.
  - Symbols follow on consecutive cycles with no gaps.
- ready_out rises in the cycle after the last symbol's cycle.
- ready_out and valid_out are never high together.
- Throughput: one word per 1+K cycles, where K is the number of symbols emitted for that word.
- All outputs are driven from registered state; there is no combinational path from inputs to outputs.

## Configuration
- DATA_UNPACK_EOP_FLUSH_EN defined:
  - On an eop word, all full symbols are emitted first.
  - If 1..6 residual bits remain, one extra symbol is emitted with those bits in the LSBs, zero-padded; it carries eop_out=1.
  - If the residual is 0, eop_out is on the last full symbol.
- Not defined: residual bits at eop are dropped, and eop_out is on the last full symbol.

## Structure
- Package data_unpack_pkg holds:
  - the IN_W/OUT_W defaults;
  - BUF_W = IN_W+OUT_W-1;
  - CNT_W = $clog2(BUF_W+1);
  - the FSM enum {IDLE, EMIT}.
- One sub-module is natural: data_unpack_acc, holding buf/cnt with append, shift-by-OUT_W and clear operations.
- The top level holds the FSM and the framing flags.

## Test plan
- Single word 0x12345678 with sop_in=1 and eop_in=1, flush enabled:
  - Expect 5 symbols: 0x78, 0x2C, 0x51, 0x11, 0x01.
  - sop_out on the first symbol, eop_out on the last; ready_out then returns to 1.
- Seven words of 0xFFFFFFFF (sop on the first, eop on the seventh):
  - Symbol counts per word are 4,5,4,5,4,5,5, for 32 symbols of 0x7F in total.
  - No flush symbol; eop_out on the 32nd symbol.
- Same packet with flush disabled, eop on the first word: 4 symbols, with eop_out on the 4th; the 4 residual bits are dropped.
- valid_in held high continuously: exactly one word is consumed per IDLE cycle, and no word is accepted while valid_out=1.
- Assert rst in the middle of EMIT:
  - The next cycle has valid_out=0 and ready_out=1.
  - A following sop word emits 4 symbols taken from data_in[27:0] only.
- sop_in on a word while 3 residual bits are pending: the residual is discarded, and the first symbol equals data_in[6:0] with sop_out=1.
